// File: rtl/stat_pkg.sv
// stat_pkg: shared types and the saturating counter add for the flow statistics controller
package stat_pkg;
  localparam int MAX_A_WIDTH = 16;
  localparam int MAX_D_WIDTH = 64;
  typedef enum logic {INIT, RUN} ctrl_state_e;
  typedef enum logic [1:0] {OP_NONE, OP_UPD, OP_CLR} op_e;
  typedef struct packed {
    op_e                    op;
    logic [MAX_A_WIDTH-1:0] flow;
    logic [15:0]            size;
  } s1_t;
  function automatic logic [MAX_D_WIDTH-1:0] sat_add(input logic [MAX_D_WIDTH-1:0] a,
                                                     input logic [15:0] b,
                                                     input int unsigned w);
    logic [MAX_D_WIDTH:0] s, m;
    s = {1'b0, a} + {{(MAX_D_WIDTH-15){1'b0}}, b};
    m = ((MAX_D_WIDTH+1)'(1) << w) - (MAX_D_WIDTH+1)'(1);
    return (s > m) ? m[MAX_D_WIDTH-1:0] : s[MAX_D_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/stat_dp_ram.sv
// stat_dp_ram: simple dual-port single-clock RAM with registered read, read-old-data on collision
module stat_dp_ram #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);
  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/stat_flow_ctrl.sv
// stat_flow_ctrl: per-flow byte counter read-modify-write with read-and-clear and same-flow forwarding
module stat_flow_ctrl
  import stat_pkg::*;
#(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] rx_flow_num_i,
  input  logic [15:0]        pkt_size_i,
  input  logic               pkt_size_en_i,
  input  logic               rd_stb_i,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  output logic               rd_ready_o,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               rd_data_val_o,
  output logic               init_done_o
);
  ctrl_state_e            state, state_n;
  logic [A_WIDTH-1:0]     cnt, hold_flow, s0_flow, ram_waddr;
  logic [MAX_A_WIDTH-1:0] fwd_flow;
  logic                   hold_v, hold_v_n, fwd_v, run, upd, rd_acc, ram_we;
  logic [D_WIDTH-1:0]     ram_q, fwd_data, old, new_val, ram_wdata;
  op_e                    s0_op;
  s1_t                    s0, s1;

  assign run         = state == RUN;
  assign init_done_o = run;
  assign rd_ready_o  = run && !hold_v;
  assign upd         = run && pkt_size_en_i;
  assign rd_acc      = rd_stb_i && rd_ready_o;

  always_comb begin
    state_n   = (state == INIT && &cnt) ? RUN : state;
    s0_op     = upd ? OP_UPD : (hold_v || rd_acc) ? OP_CLR : OP_NONE;
    s0_flow   = upd ? rx_flow_num_i : hold_v ? hold_flow : rd_flow_num_i;
    s0        = '{op: s0_op, flow: MAX_A_WIDTH'(s0_flow), size: pkt_size_i};
    hold_v_n  = upd && (rd_acc || hold_v);
    // RAM returns stale data when the previous cycle wrote the same flow
    old       = (fwd_v && fwd_flow == s1.flow) ? fwd_data : ram_q;
    new_val   = (s1.op == OP_UPD) ? D_WIDTH'(sat_add(MAX_D_WIDTH'(old), s1.size, D_WIDTH)) : '0;
    ram_we    = !run || s1.op != OP_NONE;
    ram_waddr = run ? s1.flow[A_WIDTH-1:0] : cnt;
    ram_wdata = run ? new_val : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= INIT;
    else state <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt           <= '0;
      hold_v        <= 1'b0;
      hold_flow     <= '0;
      s1            <= '0;
      fwd_v         <= 1'b0;
      fwd_flow      <= '0;
      fwd_data      <= '0;
      rd_data_o     <= '0;
      rd_data_val_o <= 1'b0;
    end else begin
      cnt           <= run ? cnt : cnt + A_WIDTH'(1);
      hold_v        <= hold_v_n;
      if (rd_acc) hold_flow <= rd_flow_num_i;
      s1            <= s0;
      fwd_v         <= run && s1.op != OP_NONE;
      fwd_flow      <= s1.flow;
      fwd_data      <= new_val;
      rd_data_val_o <= s1.op == OP_CLR;
      if (s1.op == OP_CLR) rd_data_o <= old;
    end
  end

  stat_dp_ram #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
    .clk_i   (clk_i),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (s0_flow),
    .rd_data (ram_q)
  );
endmodule

// File: tb/tb_stat_flow_ctrl.sv
// tb_stat_flow_ctrl: directed vector table plus reset/init sequences for stat_flow_ctrl (16 flows, 16-bit counters)
module tb_stat_flow_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  logic          clk_i = 1'b0, rst_i = 1'b0, pkt_size_en_i = 1'b0, rd_stb_i = 1'b0;
  logic [AW-1:0] rx_flow_num_i = '0, rd_flow_num_i = '0;
  logic [15:0]   pkt_size_i = '0;
  logic          rd_ready_o, rd_data_val_o, init_done_o;
  logic [DW-1:0] rd_data_o;
  int n_chk = 0, n_fail = 0;

  typedef struct { int upd, uf, sz, rd, rf, rdy, val, data; } vec_t;
  vec_t vecs [33];

  stat_flow_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_flow_num_i(rx_flow_num_i), .pkt_size_i(pkt_size_i),
    .pkt_size_en_i(pkt_size_en_i), .rd_stb_i(rd_stb_i), .rd_flow_num_i(rd_flow_num_i),
    .rd_ready_o(rd_ready_o), .rd_data_o(rd_data_o), .rd_data_val_o(rd_data_val_o),
    .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_init(input string name);
    int k = 0;
    while (!init_done_o && k < 100) begin
      step();
      k++;
    end
    chk(name, k, 16);
  endtask

  task automatic do_read(input logic [AW-1:0] f, input int exp, input string name);
    rd_stb_i      = 1'b1;
    rd_flow_num_i = f;
    step();
    rd_stb_i = 1'b0;
    step();
    chk({name, " val"}, 32'(rd_data_val_o), 1);
    chk({name, " data"}, 32'(rd_data_o), exp);
    step();
    chk({name, " pulse end"}, 32'(rd_data_val_o), 0);
  endtask

  initial begin
    vecs = '{
      '{1,4,1,0,0,1,0,0},     '{1,4,2,0,0,1,0,0},     '{1,4,3,0,0,1,0,0},
      '{0,0,0,1,4,1,0,0},     '{0,0,0,0,0,1,0,0},     '{0,0,0,0,0,1,1,6},
      '{0,0,0,1,4,1,0,0},     '{1,9,50,0,0,1,0,0},    '{1,5,9,0,0,1,1,0},
      '{1,3,100,0,0,1,0,0},   '{0,0,0,1,3,1,0,0},     '{1,3,5,0,0,1,0,0},
      '{0,0,0,0,0,1,1,100},   '{0,0,0,1,3,1,0,0},     '{0,0,0,0,0,1,0,0},
      '{0,0,0,0,0,1,1,5},     '{1,2,7,1,9,1,0,0},     '{1,2,7,1,5,0,0,0},
      '{1,2,7,0,0,0,0,0},     '{0,0,0,0,0,0,0,0},     '{0,0,0,0,0,1,0,0},
      '{0,0,0,0,0,1,1,50},    '{0,0,0,1,2,1,0,0},     '{0,0,0,0,0,1,0,0},
      '{0,0,0,0,0,1,1,21},    '{0,0,0,1,5,1,0,0},     '{0,0,0,0,0,1,0,0},
      '{0,0,0,0,0,1,1,9},     '{1,1,65535,0,0,1,0,0}, '{1,1,16,0,0,1,0,0},
      '{0,0,0,1,1,1,0,0},     '{0,0,0,0,0,1,0,0},     '{0,0,0,0,0,1,1,65535}
    };
    #12;
    chk("rst ready", 32'(rd_ready_o), 0);
    chk("rst init_done", 32'(init_done_o), 0);
    chk("rst val", 32'(rd_data_val_o), 0);
    chk("rst data", 32'(rd_data_o), 0);
    step();
    rst_i = 1'b1;
    wait_init("init length");
    do_read(AW'(7), 0, "init rd7");
    for (int i = 0; i < 33; i++) begin
      pkt_size_en_i = vecs[i].upd[0];
      rx_flow_num_i = vecs[i].uf[AW-1:0];
      pkt_size_i    = vecs[i].sz[15:0];
      rd_stb_i      = vecs[i].rd[0];
      rd_flow_num_i = vecs[i].rf[AW-1:0];
      chk($sformatf("v%0d ready", i), 32'(rd_ready_o), vecs[i].rdy);
      chk($sformatf("v%0d val", i), 32'(rd_data_val_o), vecs[i].val);
      if (vecs[i].val != 0) chk($sformatf("v%0d data", i), 32'(rd_data_o), vecs[i].data);
      step();
    end
    pkt_size_en_i = 1'b0;
    rd_stb_i      = 1'b0;
    pkt_size_en_i = 1'b1;
    rx_flow_num_i = AW'(6);
    pkt_size_i    = 16'd33;
    step();
    pkt_size_en_i = 1'b0;
    rd_stb_i      = 1'b1;
    rd_flow_num_i = AW'(6);
    step();
    rd_stb_i = 1'b0;
    rst_i    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("midrst val%0d", i), 32'(rd_data_val_o), 0);
      chk($sformatf("midrst init_done%0d", i), 32'(init_done_o), 0);
      step();
    end
    rst_i = 1'b1;
    wait_init("reinit length");
    for (int f = 0; f < 16; f++) do_read(AW'(f), 0, $sformatf("post rst rd%0d", f));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
